// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU pipeline: opcode constants, the
// sign-extension select encoding, the IF/ID FSM state encoding, and the
// opcode decode helper used by the IF/ID stage.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] OP_ALU  = 4'h0;
   localparam logic [3:0] OP_BGT  = 4'h4;
   localparam logic [3:0] OP_BEQ  = 4'h5;
   localparam logic [3:0] OP_BLT  = 4'h6;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Sign-extend select consumed by the downstream sign extender.
   typedef enum logic [1:0] {
      EXS_IMM8 = 2'd0,   // imm[7:0]
      EXS_HI4  = 2'd1,   // imm[7:4]
      EXS_LO4  = 2'd2    // imm[3:0]
   } ex_sign_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   typedef struct packed {
      logic     legal;
      logic     reg_write;
      logic     mem_read;
      logic     mem_write;
      logic     branch;
      logic     jump;
      logic     is_halt;
      logic     uses_rs2;
      ex_sign_e ex_sign;
   } ctrl_t;

   // Raw (ungated) control decode of a 4-bit opcode.
   function automatic ctrl_t decode_op(input logic [3:0] op);
      ctrl_t c;
      c = '{legal: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
            branch: 1'b0, jump: 1'b0, is_halt: 1'b0, uses_rs2: 1'b0,
            ex_sign: EXS_IMM8};
      case (op)
         OP_ALU: begin
            c.legal     = 1'b1;
            c.reg_write = 1'b1;
            c.uses_rs2  = 1'b1;
         end
         OP_LW: begin
            c.legal     = 1'b1;
            c.mem_read  = 1'b1;
            c.reg_write = 1'b1;
            c.ex_sign   = EXS_LO4;
         end
         OP_SW: begin
            // Store data comes from rs1, which the hazard check always covers.
            c.legal     = 1'b1;
            c.mem_write = 1'b1;
            c.ex_sign   = EXS_LO4;
         end
         OP_BGT, OP_BEQ, OP_BLT: begin
            c.legal    = 1'b1;
            c.branch   = 1'b1;
            c.uses_rs2 = 1'b1;
            c.ex_sign  = EXS_HI4;
         end
         OP_JMP: begin
            c.legal = 1'b1;
            c.jump  = 1'b1;
         end
         OP_HALT: begin
            c.legal   = 1'b1;
            c.is_halt = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Combinational load-use hazard detector.
//   rs1, rs2     : source register addresses of the instruction in ID
//   uses_rs2     : the ID instruction actually reads rs2
//   id_valid     : ID holds a real (non-bubble) instruction
//   ex_mem_read  : the instruction in ID/EX is a load
//   ex_rd        : destination register of the instruction in ID/EX
//   hazard       : ID must stall one cycle behind the load
// ---------------------------------------------------------------------------
module hazard_unit
   import cpu_pkg::*;
(
   input  logic [3:0] rs1,
   input  logic [3:0] rs2,
   input  logic       uses_rs2,
   input  logic       id_valid,
   input  logic       ex_mem_read,
   input  logic [3:0] ex_rd,
   output logic       hazard
);

   logic w_rs1_match;
   logic w_rs2_match;

   assign w_rs1_match = (rs1 == ex_rd);
   assign w_rs2_match = uses_rs2 && (rs2 == ex_rd);
   assign hazard      = ex_mem_read && id_valid && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/if_id_decode.sv
// ---------------------------------------------------------------------------
// if_id_decode
// IF/ID pipeline register plus instruction decoder, load-use stall, branch
// flush and HALT handling.
//   clk, rst            : clock, asynchronous active-high reset
//   if_instr, if_valid  : instruction from fetch
//   branch_taken        : flush IF/ID (taken branch/jump resolved in EX)
//   ex_mem_read, ex_rd  : load in ID/EX and its destination register
//   stall_if            : hold PC and fetch
//   id_valid            : decoded outputs are a real instruction
//   opcode/rs1/rs2/func/imm/ex_sign : decoded fields
//   reg_write/mem_read/mem_write/branch/jump : datapath control
//   halted, illegal     : HALT reached, unknown opcode in ID
// ---------------------------------------------------------------------------
module if_id_decode
   import cpu_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] if_instr,
   input  logic        if_valid,
   input  logic        branch_taken,
   input  logic        ex_mem_read,
   input  logic [3:0]  ex_rd,
   output logic        stall_if,
   output logic        id_valid,
   output logic [3:0]  opcode,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  func,
   output logic [7:0]  imm,
   output logic [1:0]  ex_sign,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        jump,
   output logic        halted,
   output logic        illegal
);

   state_e      r_state;
   state_e      w_state_d;
   logic [15:0] r_instr;
   logic        r_valid;
   logic [15:0] w_instr_d;
   logic        w_valid_d;

   ctrl_t       w_ctrl;
   logic        w_run;
   logic        w_pre_valid;
   logic [3:0]  w_rs2;
   logic        w_hazard;
   logic        w_id_valid;

   assign w_ctrl = decode_op(r_instr[15:12]);
   assign w_run  = (r_state == ST_RUN);

   // Validity before the hazard check; the stall itself turns ID into a bubble.
   assign w_pre_valid = r_valid && w_ctrl.legal && w_run;

   // Branches compare against instr[3:0]; instr[7:4] carries their offset.
   assign w_rs2 = w_ctrl.branch ? r_instr[3:0] : r_instr[7:4];

   hazard_unit u_hazard (
      .rs1         (r_instr[11:8]),
      .rs2         (w_rs2),
      .uses_rs2    (w_ctrl.uses_rs2),
      .id_valid    (w_pre_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .hazard      (w_hazard)
   );

   assign w_id_valid = w_pre_valid && !w_hazard;

   // Next-state and IF/ID register update.
   always_comb begin
      w_state_d = r_state;
      w_instr_d = r_instr;
      w_valid_d = r_valid;

      if (w_run && w_id_valid && w_ctrl.is_halt && !branch_taken) begin
         w_state_d = ST_HALTED;
      end

      if (branch_taken || !w_run) begin
         w_instr_d = NOP_INSTR;
         w_valid_d = 1'b0;
      end else if (!w_hazard) begin
         w_instr_d = if_instr;
         w_valid_d = if_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else begin
         r_instr <= w_instr_d;
         r_valid <= w_valid_d;
      end
   end

   assign stall_if  = w_hazard || !w_run;
   assign halted    = !w_run;
   assign id_valid  = w_id_valid;
   assign illegal   = r_valid && w_run && !w_ctrl.legal;

   assign opcode    = r_instr[15:12];
   assign rs1       = r_instr[11:8];
   assign rs2       = w_rs2;
   assign func      = r_instr[3:0];
   assign imm       = r_instr[7:0];
   assign ex_sign   = w_ctrl.ex_sign;

   assign reg_write = w_id_valid && w_ctrl.reg_write;
   assign mem_read  = w_id_valid && w_ctrl.mem_read;
   assign mem_write = w_id_valid && w_ctrl.mem_write;
   assign branch    = w_id_valid && w_ctrl.branch;
   assign jump      = w_id_valid && w_ctrl.jump;

endmodule

// File: tb/tb_if_id_decode.sv
module tb_if_id_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] if_instr;
   logic        if_valid;
   logic        branch_taken;
   logic        ex_mem_read;
   logic [3:0]  ex_rd;
   logic        stall_if, id_valid;
   logic [3:0]  opcode, rs1, rs2, func;
   logic [7:0]  imm;
   logic [1:0]  ex_sign;
   logic        reg_write, mem_read, mem_write, branch, jump, halted, illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_id_decode #(.NOP_INSTR(16'h0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_instr     (if_instr),
      .if_valid     (if_valid),
      .branch_taken (branch_taken),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .stall_if     (stall_if),
      .id_valid     (id_valid),
      .opcode       (opcode),
      .rs1          (rs1),
      .rs2          (rs2),
      .func         (func),
      .imm          (imm),
      .ex_sign      (ex_sign),
      .reg_write    (reg_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .branch       (branch),
      .jump         (jump),
      .halted       (halted),
      .illegal      (illegal)
   );

   typedef struct packed {
      logic       stall;
      logic       idv;
      logic [3:0] opc;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] func;
      logic [7:0] imm;
      logic [1:0] exs;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       br;
      logic       jp;
      logic       hlt;
      logic       ill;
   } obs_t;

   obs_t act;
   always_comb act = {stall_if, id_valid, opcode, rs1, rs2, func, imm, ex_sign,
                      reg_write, mem_read, mem_write, branch, jump, halted, illegal};

   // Reference model state: what sits in IF/ID and whether the CPU halted.
   logic [15:0] m_instr;
   logic        m_valid;
   logic        m_halt;
   bit          chk_en = 1'b0;

   function automatic obs_t model_out();
      obs_t       e;
      logic [3:0] op;
      logic       legal, uses2, is_br, pre, haz;
      op    = m_instr[15:12];
      legal = op inside {4'h0, 4'h8, 4'hB, 4'h4, 4'h5, 4'h6, 4'hC, 4'hF};
      is_br = op inside {4'h4, 4'h5, 4'h6};
      uses2 = (op == 4'h0) || is_br;
      e     = '0;
      e.opc  = op;
      e.rs1  = m_instr[11:8];
      e.rs2  = is_br ? m_instr[3:0] : m_instr[7:4];
      e.func = m_instr[3:0];
      e.imm  = m_instr[7:0];
      e.exs  = (op == 4'h8 || op == 4'hB) ? 2'd2 : (is_br ? 2'd1 : 2'd0);
      pre    = m_valid && legal && !m_halt;
      haz    = ex_mem_read && pre && (e.rs1 == ex_rd || (uses2 && e.rs2 == ex_rd));
      e.idv   = pre && !haz;
      e.stall = haz || m_halt;
      e.hlt   = m_halt;
      e.ill   = m_valid && !m_halt && !legal;
      e.rw    = e.idv && (op == 4'h0 || op == 4'h8);
      e.mr    = e.idv && (op == 4'h8);
      e.mw    = e.idv && (op == 4'hB);
      e.br    = e.idv && is_br;
      e.jp    = e.idv && (op == 4'hC);
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin : model_upd
      obs_t e;
      if (rst) begin
         m_instr <= 16'h0000;
         m_valid <= 1'b0;
         m_halt  <= 1'b0;
      end else begin
         e = model_out();
         if (!m_halt && e.idv && m_instr[15:12] == 4'hF && !branch_taken) m_halt <= 1'b1;
         if (branch_taken || m_halt) begin
            m_instr <= 16'h0000;
            m_valid <= 1'b0;
         end else if (!e.stall) begin
            m_instr <= if_instr;
            m_valid <= if_valid;
         end
      end
   end

   // Single compare process against the model.
   always @(negedge clk) begin : compare
      obs_t e;
      if (chk_en) begin
         e = model_out();
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, e);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask

   task automatic set_in(input logic [15:0] ins, input logic v, input logic bt,
                         input logic emr, input logic [3:0] erd);
      if_instr     = ins;
      if_valid     = v;
      branch_taken = bt;
      ex_mem_read  = emr;
      ex_rd        = erd;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [3:0] ops [9] = '{4'h0, 4'h8, 4'hB, 4'h4, 4'h5, 4'h6, 4'hC, 4'h1, 4'h2};

   initial begin
      int hcnt;
      logic [3:0] op;
      rst = 1'b0;
      set_in(16'h0000, 1'b0, 1'b0, 1'b0, 4'h0);
      #1 rst = 1'b1;
      #11;
      chk("rst_stall", {15'b0, stall_if}, 16'h0);
      chk("rst_idv", {15'b0, id_valid}, 16'h0);
      chk("rst_imm_exs", {6'b0, ex_sign, imm}, 16'h0);
      chk("rst_ctrl", {9'b0, reg_write, mem_read, mem_write, branch, jump, halted, illegal},
          16'h0);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // LW
      set_in(16'h8A3F, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      chk("lw_fields", {id_valid, 3'b0, rs1, imm}, 16'h8A3F);
      chk("lw_ctrl", {12'b0, ex_sign, mem_read, reg_write}, 16'h000B);

      // BEQ
      set_in(16'h52C7, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      chk("beq_fields", {branch, 3'b0, rs1, rs2, ex_sign, 2'b0}, 16'h8274);
      chk("beq_imm", {8'b0, imm}, 16'h00C7);

      // Load-use hazard on rs2 of an ALU op
      set_in(16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      set_in(16'h0456, 1'b1, 1'b0, 1'b1, 4'h1);
      #1;
      chk("haz_stall", {7'b0, stall_if, 7'b0, id_valid}, 16'h0100);
      tick();
      set_in(16'h0456, 1'b1, 1'b0, 1'b0, 4'h1);
      #1;
      chk("haz_release", {id_valid, stall_if, 2'b0, opcode, rs1, rs2}, 16'h8031);

      // Flush together with a hazard
      set_in(16'h0456, 1'b1, 1'b1, 1'b1, 4'h3);
      #1;
      chk("flush_haz_stall", {15'b0, stall_if}, 16'h0001);
      tick();
      set_in(16'h1234, 1'b1, 1'b0, 1'b1, 4'h0);
      #1;
      chk("flush_nop", {id_valid, stall_if, 6'b0, imm}, 16'h0000);

      // Illegal opcode 0001
      set_in(16'h1234, 1'b1, 1'b0, 1'b0, 4'h0);
      tick();
      chk("illegal", {illegal, id_valid, reg_write, mem_read, mem_write, branch, jump, 1'b0, imm},
          16'h8034);

      // HALT squashed by a concurrent flush
      set_in(16'hF000, 1'b1, 1'b0, 1'b0, 4'h5);
      tick();
      set_in(16'h0111, 1'b1, 1'b1, 1'b0, 4'h5);
      tick();
      chk("halt_squash", {14'b0, halted, id_valid}, 16'h0000);

      // HALT
      set_in(16'hF000, 1'b1, 1'b0, 1'b0, 4'h5);
      tick();
      set_in(16'h0111, 1'b1, 1'b0, 1'b0, 4'h5);
      tick();
      for (int i = 0; i < 12; i++) begin
         chk("halted_hold", {13'b0, halted, stall_if, id_valid}, 16'h0006);
         tick();
      end
      #1 rst = 1'b1;
      #1;
      chk("async_rst", {halted, stall_if, id_valid, illegal, reg_write, 3'b0, imm}, 16'h0000);
      #1 rst = 1'b0;

      // Randomized traffic against the model
      hcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         if (m_halt) begin
            hcnt++;
            if (hcnt > 4) begin
               rst = 1'b1;
               #1 rst = 1'b0;
               hcnt = 0;
            end
         end
         op = ($urandom_range(0, 39) == 0) ? 4'hF : ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 1) == 0)
            if_instr = {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom), 4'($urandom)};
         else
            if_instr = {op, 12'($urandom)};
         if_valid     = ($urandom_range(0, 7) != 0);
         branch_taken = ($urandom_range(0, 9) == 0);
         ex_mem_read  = ($urandom_range(0, 2) == 0);
         ex_rd        = {2'b00, 2'($urandom)};
      end

      @(posedge clk);
      #2;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_decode.md
# if_id_decode

IF/ID pipeline register and instruction decoder for the 16-bit CPU pipeline. It latches each fetched instruction, extracts register addresses and the 8-bit immediate byte with its 2-bit extension select, and generates datapath control. It also detects load-use hazards and handles branch flush and HALT. It sits between fetch and the ID/EX register, and its `imm`/`ex_sign` outputs drive the sign-extend stage directly.

## Interface
Parameters:
- `NOP_INSTR`, 16'h0000, instruction value loaded on reset or flush (decodes as a bubble).

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `if_instr` input 16: instruction from fetch.
- `if_valid` input 1: `if_instr` is valid this cycle.
- `branch_taken` input 1: EX resolved a taken branch or jump; flush IF/ID.
- `ex_mem_read` input 1: the instruction in ID/EX is a load.
- `ex_rd` input 4: destination register of the instruction in ID/EX.
- `stall_if` output 1: hold PC and fetch.
- `id_valid` output 1: decoded outputs are a real instruction; 0 means bubble.
- `opcode` output 4: instr[15:12].
- `rs1` output 4: instr[11:8], which is also rd.
- `rs2` output 4: instr[7:4] for ALU ops, instr[3:0] for branches.
- `func` output 4: instr[3:0].
- `imm` output 8: instr[7:0], passed unmodified to the sign extender.
- `ex_sign` output 2: extension select.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `halted`, `illegal` outputs, 1 bit each.

## Operation
- Opcode map:
  - 0000 ALU: `reg_write`=1, `ex_sign`=0.
  - 1000 LW: `mem_read`=1, `reg_write`=1, `ex_sign`=2.
  - 1011 SW: `mem_write`=1, `ex_sign`=2.
  - 0100/0101/0110 BGT/BEQ/BLT: `branch`=1, `ex_sign`=1, offset in instr[7:4].
  - 1100 JMP: `jump`=1, `ex_sign`=0.
  - 1111 HALT.
  - Any other opcode: `illegal`=1, all controls 0, `id_valid`=0.
- `ex_sign` encoding is fixed:
  - 2: sign-extend imm[3:0].
  - 1: sign-extend imm[7:4].
  - 0: sign-extend imm[7:0].
  - Never 3.
- When `id_valid`=0, every control output (`reg_write`, `mem_read`, `mem_write`, `branch`, `jump`) is forced to 0. Field outputs still reflect the register contents.
- Load-use hazard condition: `ex_mem_read` && `id_valid` && (`rs1`==`ex_rd` || (uses_rs2 && `rs2`==`ex_rd`)).
  - uses_rs2 is true for ALU and branch instructions only.
  - SW sources its data from `rs1`, so `rs1` is compared for SW.
- On hazard: `stall_if`=1, the IF/ID register holds, and the outputs present a bubble (`id_valid`=0) for that cycle.
- FSM states: RUN, HALTED.
  - RUN → HALTED on a clock edge where a valid HALT is in ID and `branch_taken`=0.
  - HALTED → RUN only on `rst`.
  - In HALTED: `halted`=1, `stall_if`=1, IF/ID holds NOP, `id_valid`=0.
- IF/ID register update priority at each edge:
  1. `rst`
  2. `branch_taken`: load NOP_INSTR, valid 0.
  3. HALTED: load NOP_INSTR.
  4. hazard: hold.
  5. otherwise: load `if_instr`/`if_valid`.

## Timing
- Decode latency is one cycle: an instruction presented with `if_valid` at edge N appears on the outputs after edge N, combinationally from the register.
- `stall_if` is combinational from register state and the `ex_*` inputs, within the same cycle.
- Reset (asynchronous):
  - register = NOP_INSTR with valid 0; state RUN.
  - `id_valid`, all controls, `stall_if`, `halted`, `illegal` = 0.
  - `ex_sign`=0, `imm`=0.
- A hazard stall lasts exactly one cycle. The following cycle, ID/EX holds the bubble, `ex_mem_read`=0, and the instruction proceeds.
- `branch_taken` together with a hazard: the flush wins, the register loads NOP, and `stall_if` deasserts the next cycle.
- `branch_taken` together with HALT in ID: the HALT is squashed and the FSM stays in RUN.
- `rst` asserted mid-stall or in HALTED clears everything immediately, without waiting for a clock edge.
- `if_valid`=0 while not stalled loads a bubble.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_ALU, OP_LW, OP_SW, OP_BGT, OP_BEQ, OP_BLT, OP_JMP, OP_HALT);
  - `ex_sign` constants (EXS_IMM8=0, EXS_HI4=1, EXS_LO4=2);
  - the state encoding (ST_RUN, ST_HALTED).
- One sub-module, `hazard_unit`: the purely combinational load-use comparator. Inputs are `rs1`, `rs2`, uses_rs2, `id_valid`, `ex_mem_read`, `ex_rd`; output is hazard.

## Test plan
- Reset, then feed LW 16'h8A3F with valid → next cycle: `id_valid`=1, `rs1`=A, `imm`=8'h3F, `ex_sign`=2, `mem_read`=1, `reg_write`=1.
- Feed BEQ 16'h52C7 → `branch`=1, `rs1`=2, `rs2`=7, `imm`=8'hC7, `ex_sign`=1.
- In ID, ALU 16'h0312 with `ex_mem_read`=1 and `ex_rd`=1 → `stall_if`=1 and `id_valid`=0 for one cycle. Next cycle, with `ex_mem_read`=0, the same instruction appears with `id_valid`=1.
- `branch_taken`=1 on the same cycle as a hazard → next cycle: register holds NOP, `id_valid`=0, `stall_if`=0.
- HALT 16'hF000 → after one edge: `halted`=1 and `stall_if`=1, persisting 10+ cycles. Asynchronous `rst` pulse between edges → all outputs 0 immediately.
- Opcode 0001 → `illegal`=1, `id_valid`=0, all controls 0.
